// File: rtl/video_timing_gen.sv
// Raster timing generator: hsync/vsync/de and active x/y from two four-phase FSMs.
// Define VIDEO_TIMING_SYNC_NEG_EN for active-low hsync/vsync (idle and reset level 1).
module video_timing_gen #(
    parameter int ADDR_W   = 11,
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_W-1:0] y,
    output logic              line_end,
    output logic              frame_start
);

    typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCS, H_BACK} h_state_t;
    typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCS, V_BACK} v_state_t;

`ifdef VIDEO_TIMING_SYNC_NEG_EN
    localparam logic SYNC_IDLE = 1'b1;
`else
    localparam logic SYNC_IDLE = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] H_ACT_LAST  = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] H_FP_LAST   = ADDR_W'(H_FP - 1);
    localparam logic [ADDR_W-1:0] H_SYNC_LAST = ADDR_W'(H_SYNC - 1);
    localparam logic [ADDR_W-1:0] H_BP_LAST   = ADDR_W'(H_BP - 1);
    localparam logic [ADDR_W-1:0] V_ACT_LAST  = ADDR_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] V_FP_LAST   = ADDR_W'(V_FP - 1);
    localparam logic [ADDR_W-1:0] V_SYNC_LAST = ADDR_W'(V_SYNC - 1);
    localparam logic [ADDR_W-1:0] V_BP_LAST   = ADDR_W'(V_BP - 1);

    h_state_t          r_h_state, w_h_state_nxt;
    v_state_t          r_v_state, w_v_state_nxt;
    logic [ADDR_W-1:0] r_h_cnt, w_h_cnt_nxt;
    logic [ADDR_W-1:0] r_v_cnt, w_v_cnt_nxt;
    logic [ADDR_W-1:0] w_h_last_val, w_v_last_val;
    logic              w_h_last, w_v_last, w_line_end, w_de;

    logic              r_hsync, r_vsync, r_de, r_line_end, r_frame_start;
    logic [ADDR_W-1:0] r_x, r_y;

    always_comb begin
        w_h_state_nxt = r_h_state;
        w_h_cnt_nxt   = r_h_cnt + ADDR_W'(1);
        w_h_last_val  = H_ACT_LAST;
        case (r_h_state)
            H_ACT:   w_h_last_val = H_ACT_LAST;
            H_FRONT: w_h_last_val = H_FP_LAST;
            H_SYNCS: w_h_last_val = H_SYNC_LAST;
            H_BACK:  w_h_last_val = H_BP_LAST;
            default: w_h_last_val = H_ACT_LAST;
        endcase
        w_h_last   = (r_h_cnt == w_h_last_val);
        w_line_end = (r_h_state == H_BACK) && w_h_last;
        if (w_h_last) begin
            w_h_cnt_nxt = '0;
            case (r_h_state)
                H_ACT:   w_h_state_nxt = H_FRONT;
                H_FRONT: w_h_state_nxt = H_SYNCS;
                H_SYNCS: w_h_state_nxt = H_BACK;
                H_BACK:  w_h_state_nxt = H_ACT;
                default: w_h_state_nxt = H_ACT;
            endcase
        end
    end

    // Vertical FSM only steps on the last pixel of a line.
    always_comb begin
        w_v_state_nxt = r_v_state;
        w_v_cnt_nxt   = r_v_cnt;
        w_v_last_val  = V_ACT_LAST;
        case (r_v_state)
            V_ACT:   w_v_last_val = V_ACT_LAST;
            V_FRONT: w_v_last_val = V_FP_LAST;
            V_SYNCS: w_v_last_val = V_SYNC_LAST;
            V_BACK:  w_v_last_val = V_BP_LAST;
            default: w_v_last_val = V_ACT_LAST;
        endcase
        w_v_last = (r_v_cnt == w_v_last_val);
        if (w_line_end) begin
            if (w_v_last) begin
                w_v_cnt_nxt = '0;
                case (r_v_state)
                    V_ACT:   w_v_state_nxt = V_FRONT;
                    V_FRONT: w_v_state_nxt = V_SYNCS;
                    V_SYNCS: w_v_state_nxt = V_BACK;
                    V_BACK:  w_v_state_nxt = V_ACT;
                    default: w_v_state_nxt = V_ACT;
                endcase
            end else begin
                w_v_cnt_nxt = r_v_cnt + ADDR_W'(1);
            end
        end
        w_de = (r_h_state == H_ACT) && (r_v_state == V_ACT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_state     <= H_ACT;
            r_v_state     <= V_ACT;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_h_state     <= w_h_state_nxt;
            r_v_state     <= w_v_state_nxt;
            r_h_cnt       <= w_h_cnt_nxt;
            r_v_cnt       <= w_v_cnt_nxt;
            r_hsync       <= (r_h_state == H_SYNCS);
            r_vsync       <= (r_v_state == V_SYNCS);
            r_de          <= w_de;
            r_x           <= w_de ? r_h_cnt : '0;
            r_y           <= w_de ? r_v_cnt : '0;
            r_line_end    <= w_line_end;
            r_frame_start <= w_de && (r_h_cnt == '0) && (r_v_cnt == '0);
        end else begin
            // Stalled: hold everything, but one-shot pulses must not repeat.
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hsync       = r_hsync ^ SYNC_IDLE;
    assign vsync       = r_vsync ^ SYNC_IDLE;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: vector table, corner sequences and a raster-position reference model.
module tb_video_timing_gen;

    localparam int AW  = 6;
    localparam int HA  = 4;
    localparam int HFP = 1;
    localparam int HS  = 2;
    localparam int HBP = 1;
    localparam int VA  = 3;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int VW  = 5 + 2 * AW;

`ifdef VIDEO_TIMING_SYNC_NEG_EN
    localparam logic SI = 1'b1;
`else
    localparam logic SI = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          hsync, vsync, de, line_end, frame_start;
    logic [AW-1:0] x, y;

    video_timing_gen #(
        .ADDR_W(AW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_end(line_end), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: linear pixel position within the frame.
    int unsigned   m_pos = 0;
    logic          e_de = 0, e_hs = 0, e_vs = 0, e_le = 0, e_fs = 0;
    logic [AW-1:0] e_x = '0, e_y = '0;

    int unsigned n_clk = 0, last_fs = 0, fs_period = 0;
    int          cnt_de = 0, cnt_vs = 0;
    logic [7:0]  y_mask = '0;

    task automatic model_edge(input logic r, input logic e);
        int unsigned col, row;
        if (r) begin
            {e_de, e_hs, e_vs, e_le, e_fs} = '0;
            e_x = '0; e_y = '0; m_pos = 0;
        end else if (e) begin
            col  = m_pos % HT;
            row  = m_pos / HT;
            e_de = (col < HA) && (row < VA);
            e_hs = (col >= HA + HFP) && (col < HA + HFP + HS);
            e_vs = (row >= VA + VFP) && (row < VA + VFP + VS);
            e_x  = e_de ? AW'(col) : '0;
            e_y  = e_de ? AW'(row) : '0;
            e_le = (col == HT - 1);
            e_fs = (m_pos == 0);
            m_pos = (m_pos + 1) % (HT * VT);
        end else begin
            e_le = 1'b0;
            e_fs = 1'b0;
        end
    endtask

    function automatic logic [VW-1:0] act_vec();
        return {de, hsync ^ SI, vsync ^ SI, line_end, frame_start, x, y};
    endfunction

    task automatic check_vec(input string name, input logic [VW-1:0] exp);
        logic [VW-1:0] a;
        a = act_vec();
        n_checks++;
        if (a !== exp) begin
            n_errors++;
            $display("FAIL %s @clk %0d: got de,hs,vs,le,fs=%b x=%0d y=%0d, expected de,hs,vs,le,fs=%b x=%0d y=%0d",
                     name, n_clk, a[VW-1 -: 5], a[2*AW-1 -: AW], a[AW-1:0],
                     exp[VW-1 -: 5], exp[2*AW-1 -: AW], exp[AW-1:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @clk %0d: got %0d, expected %0d", name, n_clk, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e);
        @(negedge clk);
        rst = r;
        en  = e;
        @(posedge clk);
        model_edge(r, e);
        n_clk++;
        #2;
        check_vec("model", {e_de, e_hs, e_vs, e_le, e_fs, e_x, e_y});
        if (r) begin
            cnt_de = 0; cnt_vs = 0; y_mask = '0;
        end else begin
            if (de === 1'b1) begin
                cnt_de++;
                if (y < 8) y_mask[y[2:0]] = 1'b1;
            end
            if ((vsync ^ SI) === 1'b1) cnt_vs++;
        end
        if (frame_start === 1'b1) begin
            fs_period = n_clk - last_fs;
            last_fs   = n_clk;
        end
    endtask

    typedef struct {
        logic          r;
        logic          e;
        logic          de, hs, vs, le, fs;
        logic [AW-1:0] x, y;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic r, e, d, hs, vs, le, fs, input int xv, yv);
        vec_t v;
        v.r = r; v.e = e; v.de = d; v.hs = hs; v.vs = vs; v.le = le; v.fs = fs;
        v.x = AW'(xv); v.y = AW'(yv);
        return v;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        // Reset for 3 cycles, then the first line with en held high.
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 1, 0, 0, 0, 1, 0, 0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0, 2, 0);
        tbl[6]  = mk(0, 1, 1, 0, 0, 0, 0, 3, 0);
        tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].e);
            check_vec($sformatf("first_line[%0d]", i),
                      {tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].le, tbl[i].fs, tbl[i].x, tbl[i].y});
        end

        // Rest of the first frame: cycles 8..47.
        for (int i = 8; i < 48; i++) step(0, 1);
        check_int("frame_de_cycles", cnt_de, HA * VA);
        check_int("frame_vsync_cycles", cnt_vs, VS * HT);
        check_int("frame_y_values", int'(y_mask), 7);
        step(0, 1);
        check_int("frame_start_at_48", int'(frame_start), 1);
        check_int("frame_period", int'(fs_period), HT * VT);

        // Stall for 5 cycles while x=2.
        step(0, 1);
        step(0, 1);
        check_int("pre_stall_x", int'(x), 2);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            check_vec($sformatf("stall_hold[%0d]", i), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, AW'(2), AW'(0)});
        end
        step(0, 1);
        check_int("resume_x", int'(x), 3);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(0, 1);
            if (frame_start === 1'b1) found = 1;
        end
        check_int("stall_frame_found", int'(found), 1);
        check_int("stall_frame_period", int'(fs_period), HT * VT + 5);

        // Reset for one cycle during vsync, with en also high.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(0, 1);
            if ((vsync ^ SI) === 1'b1) found = 1;
        end
        check_int("reach_vsync", int'(found), 1);
        step(1, 1);
        check_vec("mid_reset_outputs", '0);
        check_int("mid_reset_vsync_idle", int'(vsync), int'(SI));
        step(0, 0);
        check_vec("post_reset_idle", '0);
        step(0, 1);
        check_vec("post_reset_first_pixel", {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, AW'(0), AW'(0)});

        // Random enable pattern with occasional resets against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

- Generates raster timing for the median-filter output path:
  - `hsync` and `vsync` pulses.
  - `de`, the active-video qualifier.
  - Active-area pixel coordinates `x` / `y`.
- It is the transmit-side counterpart of the line-address logic, which consumes `hsync`/`vsync`. It drives the downstream video interface and paces readout of the filtered frame.
- Horizontal and vertical timing are each run by a four-phase state machine with programmable porch and sync lengths.

## Interface

- `ADDR_W`, 11: width of `x`, `y` and the internal counters. Must hold `H_TOTAL-1` and `V_TOTAL-1`.
- `H_ACTIVE`, 1280: active pixels per line.
- `H_FP`, 110: horizontal front porch, in pixels.
- `H_SYNC`, 40: hsync width, in pixels.
- `H_BP`, 220: horizontal back porch, in pixels.
- `V_ACTIVE`, 720: active lines per frame.
- `V_FP`, 5: vertical front porch, in lines.
- `V_SYNC`, 5: vsync width, in lines.
- `V_BP`, 20: vertical back porch, in lines.

Ports:

- `clk` in 1: pixel-domain clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: pixel-rate enable. Timing advances only on cycles where `en`=1.
- `hsync` out 1: horizontal sync pulse.
- `vsync` out 1: vertical sync pulse.
- `de` out 1: high during active pixels.
- `x` out `ADDR_W`: active column, 0..`H_ACTIVE-1`. Holds 0 outside the active area.
- `y` out `ADDR_W`: active row, 0..`V_ACTIVE-1`. Holds 0 outside the active area.
- `line_end` out 1: one-cycle pulse on the last pixel of every line, including blanking lines.
- `frame_start` out 1: one-cycle pulse on pixel (0,0).

## Operation

- Derived totals:
  - `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP`
  - `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP`
- Horizontal FSM:
  - States: `H_ACT` → `H_FRONT` → `H_SYNCS` → `H_BACK` → `H_ACT`.
  - `h_cnt` counts cycles within the current state.
  - On the last cycle of a state, `h_cnt` returns to 0 and the FSM moves to the next state.
- Vertical FSM:
  - States: `V_ACT` → `V_FRONT` → `V_SYNCS` → `V_BACK` → `V_ACT`.
  - Advances only on the last cycle of `H_BACK` (end of line), using `v_cnt` in the same manner as the horizontal FSM.
- Zero-length porch parameters are illegal; the implementation may assert on them.
- Output decode is registered, one enabled cycle after the state/counter update:
  - `de` = (`H_ACT` && `V_ACT`).
  - `hsync` = `H_SYNCS`.
  - `vsync` = `V_SYNCS`. It changes only on line boundaries, in the same cycle as the first pixel of a line.
  - `x` = `h_cnt` while `de`, else 0.
  - `y` = `v_cnt` while `de`, else 0.
  - `line_end` = last cycle of `H_BACK`.
  - `frame_start` = first cycle of `H_ACT` within the first line of `V_ACT`.
- `en`=0: FSMs, counters and every output hold their values. Pulses are not re-issued: `line_end` and `frame_start` are forced to 0 while `en`=0.
- Reset:
  - On the clock edge with `rst`=1, both FSMs go to `H_ACT`/`V_ACT` and counters go to 0.
  - All outputs reset to 0 (or to the inactive level, see Configuration).
  - Reset mid-line or mid-frame aborts the frame with no trailing sync.
- First output after reset: on the first cycle with `en`=1 after `rst` deasserts, the registered outputs show pixel (0,0) with `de`=1 and `frame_start`=1.
- Arithmetic:
  - Counters are unsigned `ADDR_W` bits and compare with `==` against (length-1) constants.
  - They never overflow; wrap is explicit.

## Timing

- Latency: 1 enabled cycle from state/counter update to outputs. All outputs change together.
- `hsync` width: exactly `H_SYNC` enabled cycles per line, on every line including vertical blanking.
- `vsync` width: exactly `V_SYNC*H_TOTAL` enabled cycles.
- `de` per line: high for `H_ACTIVE` consecutive enabled cycles on each of `V_ACTIVE` lines per frame.
- Frame period: `frame_start` pulses exactly every `H_TOTAL*V_TOTAL` enabled cycles.
- `line_end` occurs in the enabled cycle immediately before the next line's first pixel.
- Simultaneous `rst` and `en`: `rst` wins.

## Configuration

- `VIDEO_TIMING_SYNC_NEG_EN` defined:
  - `hsync` and `vsync` are active-low: idle 1, pulse 0.
  - Both reset to 1.
- `VIDEO_TIMING_SYNC_NEG_EN` not defined:
  - Syncs are active-high and reset to 0.
- `de`, `line_end` and `frame_start` are active-high in both builds.

## Test plan

Bench parameters: `H_ACTIVE`=4, `H_FP`=1, `H_SYNC`=2, `H_BP`=1 (`H_TOTAL`=8); `V_ACTIVE`=3, `V_FP`=1, `V_SYNC`=1, `V_BP`=1 (`V_TOTAL`=6).

- **Reset and first line:** `rst` high 3 cycles, then `en`=1 constantly.
  - Required sequence: `de`=1 for 4 cycles with `x`=0,1,2,3 and `y`=0.
  - Then `de`=0 for 4 cycles.
  - `hsync`=1 on line cycles 5–6 (0-based).
  - `line_end`=1 on cycle 7.
  - `frame_start`=1 on cycle 0 only.
- **Full frame:** run 48 cycles.
  - `de` high for exactly 12 cycles.
  - `y` takes 0,1,2.
  - `vsync`=1 for exactly 8 cycles, spanning line 4.
  - `frame_start` repeats at cycle 48.
- **Enable stall:** drop `en` for 5 cycles while `x`=2.
  - All outputs hold: `x`=2, `de`=1.
  - `line_end` and `frame_start` stay 0.
  - Resume gives `x`=3 next.
  - Frame period becomes 53 clocks.
- **Reset mid-frame:** assert `rst` for 1 cycle during `vsync`.
  - Next cycle: all outputs 0.
  - The first enabled cycle after reset shows `frame_start`=1, `x`=0, `y`=0.
- **Polarity build:** compile with `VIDEO_TIMING_SYNC_NEG_EN`.
  - `hsync` and `vsync` read 1 in reset and at idle.
  - `hsync` is 0 on line cycles 5–6.
  - All other outputs are identical to the default build.
